// File: rtl/fp_normalizer.sv
// Post-add normalization stage for the half-precision adder: it takes the raw mantissa sum and returns a normalized mantissa and an adjusted exponent.
// Optional feature: define NORM_STICKY_EN so that sticky_out reports the LSB dropped on the carry path.
module fp_normalizer #(
   parameter int MANT_W = 11,
   parameter int EXP_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MANT_W:0]   sum_mant,
   input  logic [EXP_W-1:0]  exp_in,
   input  logic              sign_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W-1:0] mant_out,
   output logic [EXP_W-1:0]  exp_out,
   output logic              sign_out,
   output logic              zero_out,
   output logic              ovf_out,
   output logic              unf_out,
   output logic              sticky_out
);

   localparam int LZ_W = $clog2(MANT_W);
   localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

   typedef enum logic [1:0] {IDLE, CHECK, LSHIFT, DONE} state_t;

   state_t            state;
   logic [MANT_W:0]   sum_q;
   logic [EXP_W-1:0]  exp_q;
   logic              sign_q;
   logic [LZ_W-1:0]   lz_q;

   logic [EXP_W:0]    exp_inc;
   logic [LZ_W-1:0]   lz_next;
   logic [MANT_W-1:0] sh0, sh1, sh2, sh3;

   // The count is taken from the highest set bit, so the last match in an upward scan wins.
   function automatic logic [LZ_W-1:0] lead_zeros(input logic [MANT_W-1:0] v);
      lead_zeros = '0;
      for (int i = 0; i < MANT_W; i++)
         if (v[i]) lead_zeros = LZ_W'(MANT_W - 1 - i);
   endfunction

   // NOTE: every always_comb output is assigned unconditionally, so no latches are inferred; blocking '=' is used here and '<=' only in clocked logic.
   always_comb begin
      exp_inc = {1'b0, exp_q} + (EXP_W+1)'(1);
      lz_next = lead_zeros(sum_q[MANT_W-1:0]);
      sh0     = lz_q[0] ? (sum_q[MANT_W-1:0] << 1) : sum_q[MANT_W-1:0];
      sh1     = lz_q[1] ? (sh0 << 2) : sh0;
      sh2     = lz_q[2] ? (sh1 << 4) : sh1;
      sh3     = lz_q[3] ? (sh2 << 8) : sh2;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         mant_out  <= '0;
         exp_out   <= '0;
         sign_out  <= 1'b0;
         zero_out  <= 1'b0;
         ovf_out   <= 1'b0;
         unf_out   <= 1'b0;
         sum_q     <= '0;
         exp_q     <= '0;
         sign_q    <= 1'b0;
         lz_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sum_q    <= sum_mant;
                  exp_q    <= exp_in;
                  sign_q   <= sign_in;
                  in_ready <= 1'b0;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               sign_out <= sign_q;
               zero_out <= 1'b0;
               ovf_out  <= 1'b0;
               unf_out  <= 1'b0;
               if (sum_q == '0) begin
                  mant_out  <= '0;
                  exp_out   <= '0;
                  zero_out  <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (sum_q[MANT_W]) begin
                  if (exp_inc >= EXP_MAX) begin
                     mant_out <= '0;
                     exp_out  <= EXP_MAX[EXP_W-1:0];
                     ovf_out  <= 1'b1;
                  end else begin
                     mant_out <= sum_q[MANT_W:1];
                     exp_out  <= exp_inc[EXP_W-1:0];
                  end
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (sum_q[MANT_W-1]) begin
                  // An all-ones exponent on input is already infinity.
                  if ({1'b0, exp_q} >= EXP_MAX) begin
                     mant_out <= '0;
                     exp_out  <= EXP_MAX[EXP_W-1:0];
                     ovf_out  <= 1'b1;
                  end else begin
                     mant_out <= sum_q[MANT_W-1:0];
                     exp_out  <= exp_q;
                  end
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  lz_q  <= lz_next;
                  state <= LSHIFT;
               end
            end
            LSHIFT: begin
               if (exp_q <= EXP_W'(lz_q)) begin
                  mant_out <= '0;
                  exp_out  <= '0;
                  unf_out  <= 1'b1;
               end else begin
                  mant_out <= sh3;
                  exp_out  <= exp_q - EXP_W'(lz_q);
               end
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef NORM_STICKY_EN
   // The value is set while the state is CHECK. It is nonzero only on the carry path, and LSHIFT leaves it unchanged.
   always_ff @(posedge clk) begin
      if (reset)
         sticky_out <= 1'b0;
      else if (state == CHECK)
         sticky_out <= sum_q[MANT_W] & sum_q[0];
   end
`else
   assign sticky_out = 1'b0;
`endif

endmodule

// File: doc/fp_normalizer.md
Name: fp_normalizer

Overview:
- Post-add normalization stage of the half-precision float adder. It is the left-shift counterpart of the alignment right-shifter.
- Takes the raw 12-bit mantissa sum (carry + hidden + 10 fraction bits), the exponent and the sign.
- Produces a normalized 11-bit mantissa (hidden bit at MSB) and an adjusted exponent.
- Multi-cycle FSM with valid/ready handshakes on both sides. Contains an internal left barrel shift by leading-zero count.

Parameters:
- MANT_W, 11, normalized mantissa width incl. hidden bit; input sum is MANT_W+1 bits
- EXP_W, 5, exponent width; all-ones exponent (31) means overflow/infinity

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input operand valid
- in_ready  output  1  block can accept an operand
- sum_mant  input  12  raw sum; bit11 carry, bit10 hidden position
- exp_in  input  5  pre-normalization exponent
- sign_in  input  1  result sign, passed through
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- mant_out  output  11  normalized mantissa, bit10 = 1 unless zero/overflow/underflow
- exp_out  output  5  adjusted exponent
- sign_out  output  1  registered sign
- zero_out  output  1  result is exact zero
- ovf_out  output  1  exponent overflow
- unf_out  output  1  exponent underflow, flushed to zero
- sticky_out  output  1  OR of bits shifted out (see Optional Feature)

Behaviour:
- Reset: state IDLE; in_ready=1. out_valid, mant_out, exp_out, sign_out, zero_out, ovf_out, unf_out, sticky_out all 0.
- Reset mid-operation: the in-flight operand is discarded and no result is produced.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready (cycle T): register sum_mant, exp_in, sign_in; go to CHECK.
- CHECK (T+1), first matching rule applies:
  - sum==0: mant=0, exp=0, zero=1; go to DONE.
  - bit11=1: mant=sum[11:1] (LSB dropped), exp=exp+1.
    - If exp+1 == 31: ovf=1, mant forced to 0, exp=31.
    - Go to DONE.
  - bit10=1: mant=sum[10:0], exp unchanged; go to DONE.
  - Otherwise: compute lz = leading zeros of sum[10:0] (range 1..10, 4-bit register); go to LSHIFT.
- LSHIFT (T+2):
  - If exp <= lz: unf=1, mant=0, exp=0, zero=0. Denormals are not produced.
  - Else: mant = sum[10:0] << lz (zero fill), exp = exp - lz.
  - Go to DONE.
- DONE:
  - out_valid=1; all outputs held stable while out_ready=0.
  - On out_ready: out_valid drops next cycle; go to IDLE.
- Latency from accept to out_valid:
  - carry, normal and zero paths: out_valid asserted in cycle T+2.
  - left-shift path: out_valid asserted in cycle T+3.
- Throughput: one operand in flight; in_ready=0 in every state except IDLE.
- Flags are mutually exclusive; each is updated with every result and valid only while out_valid=1.
- Left shift is built from 4 mux layers (shift by 1, 2, 4, 8) on lz bits; shift amounts above 10 are never generated.
- Exponent arithmetic is performed 6 bits wide to detect wrap; exp_in=31 on input is treated as overflow on any path producing exp >= 31.

Optional Feature:
- Macro: NORM_STICKY_EN
- Defined: sticky_out = dropped sum[0] on the carry path; 0 on all other paths.
- Undefined: sticky_out tied to 0 and no extra register is inferred.

Test Plan:
- Carry path: sum_mant=12'hA01, exp_in=14 -> mant_out=11'h500, exp_out=15, out_valid at T+2; sticky_out=1 with NORM_STICKY_EN, 0 without.
- Already normal: sum_mant=12'h4C0, exp_in=10, sign_in=1 -> mant_out=11'h4C0, exp_out=10, sign_out=1, all flags 0, out_valid at T+2.
- Left shift: sum_mant=12'h013, exp_in=15 -> lz=6, mant_out=11'h4C0, exp_out=9, out_valid at T+3.
- Boundaries:
  - sum_mant=12'h001, exp_in=5 -> unf_out=1, mant_out=0, exp_out=0.
  - sum_mant=12'h800, exp_in=30 -> ovf_out=1, exp_out=31, mant_out=0.
  - sum_mant=0 -> zero_out=1.
- Handshake: hold out_ready=0 for 3 cycles after out_valid -> outputs stable, in_ready=0; release -> out_valid low next cycle, in_ready=1.
- Reset mid-op: assert reset in LSHIFT cycle -> next cycle out_valid=0, in_ready=1, no result emitted.
